// File: rtl/fact_engine.sv
// rtl/fact_engine.sv - iterative factorial / double-factorial engine
// Valid/ready operand in, valid/ready result out; one multiply per RUN cycle.
module fact_engine #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in0,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out0,
  output logic         ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t         state_q, state_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           dbl_q, dbl_d;
  logic           mul_seen_q, mul_seen_d;
  logic           live_q;
  logic [N-1:0]   step;
  logic [2*N-1:0] prod;
  logic           mul_en;
  logic           accept;

  assign step   = {{(N-2){1'b0}}, dbl_q, ~dbl_q};
  assign prod   = {{N{1'b0}}, acc_q} * {{N{1'b0}}, cnt_q};
  assign accept = in_valid && in_ready;
  // Odd n!! takes a final x1 step so that it costs ceil(n/2) multiplications.
  assign mul_en = (cnt_q > ONE) || (dbl_q && mul_seen_q && (cnt_q == ONE));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (!mul_en)   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // live_q keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready  = (state_q == IDLE) && live_q;
    out_valid = (state_q == DONE);
    out0      = out_valid ? acc_q : '0;
    ovf       = out_valid ? ovf_q : 1'b0;
  end

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    dbl_d      = dbl_q;
    mul_seen_d = mul_seen_q;
    if (state_q == IDLE && accept) begin
      acc_d      = ONE;
      cnt_d      = in0;
      ovf_d      = 1'b0;
      dbl_d      = mode;
      mul_seen_d = 1'b0;
    end else if (state_q == RUN && mul_en) begin
      acc_d      = prod[N-1:0];
      ovf_d      = ovf_q | (|prod[2*N-1:N]);
      cnt_d      = (cnt_q > step) ? (cnt_q - step) : '0;
      mul_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      dbl_q      <= 1'b0;
      mul_seen_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      dbl_q      <= dbl_d;
      mul_seen_q <= mul_seen_d;
      live_q     <= 1'b1;
    end
  end

endmodule
